bpsk_modulator: RTL

- BPSK transmitter: accepts a serial bit stream over a valid/ready handshake and emits a signed sample stream, one symbol per WAVELENGTH clocks.
- Bit 0 transmits the carrier from sine_wave unchanged. Bit 1 transmits the inverted carrier. This is the polarity our demodulator decodes: positive correlation gives 0, negative gives 1.
- Sits between the framing/data source and the DAC/channel model. A small input FIFO absorbs source burstiness so back-to-back symbols are phase-continuous.

---
 rtl/bpsk_modulator_pkg.sv | 25 ++
 rtl/bpsk_bit_fifo.sv | 53 +++++
 rtl/sine_wave.sv | 49 ++++
 rtl/bpsk_modulator.sv | 110 +++++++++++
 4 files changed

// File: rtl/bpsk_modulator_pkg.sv
// Shared BPSK types and constants.
// Common to the modulator, demodulator and sine_wave.
package bpsk_modulator_pkg;

  localparam int WAVELENGTH = 32;
  localparam int DATA_WIDTH = 8;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    TX   = 1'b1
  } state_t;

  localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  // Two's-complement negation that clamps the most negative code.
  function automatic sample_t sat_neg(sample_t a);
    if (a == SAMPLE_MIN)
      return SAMPLE_MAX;
    return -a;
  endfunction

endpackage

// File: rtl/bpsk_bit_fifo.sv
// 1-bit-wide synchronous FIFO feeding the modulator.
// Pointers wrap naturally since DEPTH is a power of two.
module bpsk_bit_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sine_wave.sv
// Combinational carrier lookup, one cycle per WAVELENGTH phases.
// The negative peak uses the full-scale code.
module sine_wave
  import bpsk_modulator_pkg::*;
(
  input  logic [15:0] phase,
  output sample_t     amp
);

  always_comb begin
    amp = '0;
    case (phase)
      16'd0:  amp = sample_t'(0);
      16'd1:  amp = sample_t'(25);
      16'd2:  amp = sample_t'(49);
      16'd3:  amp = sample_t'(71);
      16'd4:  amp = sample_t'(90);
      16'd5:  amp = sample_t'(106);
      16'd6:  amp = sample_t'(117);
      16'd7:  amp = sample_t'(125);
      16'd8:  amp = sample_t'(127);
      16'd9:  amp = sample_t'(125);
      16'd10: amp = sample_t'(117);
      16'd11: amp = sample_t'(106);
      16'd12: amp = sample_t'(90);
      16'd13: amp = sample_t'(71);
      16'd14: amp = sample_t'(49);
      16'd15: amp = sample_t'(25);
      16'd16: amp = sample_t'(0);
      16'd17: amp = sample_t'(-25);
      16'd18: amp = sample_t'(-49);
      16'd19: amp = sample_t'(-71);
      16'd20: amp = sample_t'(-90);
      16'd21: amp = sample_t'(-106);
      16'd22: amp = sample_t'(-117);
      16'd23: amp = sample_t'(-125);
      16'd24: amp = sample_t'(-128);
      16'd25: amp = sample_t'(-125);
      16'd26: amp = sample_t'(-117);
      16'd27: amp = sample_t'(-106);
      16'd28: amp = sample_t'(-90);
      16'd29: amp = sample_t'(-71);
      16'd30: amp = sample_t'(-49);
      16'd31: amp = sample_t'(-25);
      default: amp = '0;
    endcase
  end

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK transmitter: bit 0 sends the carrier, bit 1 its inverse.
// Queued bits run back to back with a continuous phase.
module bpsk_modulator
  import bpsk_modulator_pkg::sample_t;
  import bpsk_modulator_pkg::state_t;
  import bpsk_modulator_pkg::IDLE;
  import bpsk_modulator_pkg::TX;
  import bpsk_modulator_pkg::sat_neg;
#(
  parameter int WAVELENGTH = bpsk_modulator_pkg::WAVELENGTH,
  parameter int DATA_WIDTH = bpsk_modulator_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic signed [DATA_WIDTH-1:0] sample,
  output logic                         sample_valid,
  output logic                         symbol_start,
  output logic                         busy
);

  localparam int PW = $clog2(WAVELENGTH);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] phase;
  logic          cur_bit;
  logic          last;
  logic          pop;
  logic          fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  sample_t       amp;
  sample_t       mod;

  bpsk_bit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (bit_valid),
    .din     (bit_in),
    .pop     (pop),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  sine_wave u_sine (
    .phase (16'(phase)),
    .amp   (amp)
  );

  assign bit_ready = !fifo_full;
  assign last      = (phase == PW'(WAVELENGTH - 1));
  assign mod       = cur_bit ? sat_neg(amp) : amp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = TX;
      TX:      if (last && fifo_empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pop decision sees only bits queued before this edge.
  always_comb begin
    pop  = !fifo_empty && (state == IDLE || last);
    busy = (state == TX) || (fifo_count != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase        <= '0;
      cur_bit      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      symbol_start <= 1'b0;
    end else begin
      if (pop)
        cur_bit <= fifo_dout;
      if (state == TX) begin
        sample       <= mod;
        sample_valid <= 1'b1;
        symbol_start <= (phase == '0);
        phase        <= last ? '0 : phase + 1'b1;
      end else begin
        sample       <= '0;
        sample_valid <= 1'b0;
        symbol_start <= 1'b0;
        phase        <= '0;
      end
    end
  end

endmodule
